// File: rtl/vector_logic_gate_pkg.sv
// Shared definitions for the vector logic unit: opcodes, FSM states, zero constants
// and the unary-opcode classifier.
package vector_logic_gate_pkg;

   localparam logic [2:0] OP_NOT_A = 3'd0;
   localparam logic [2:0] OP_NOT_B = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_NAND  = 3'd5;
   localparam logic [2:0] OP_NOR   = 3'd6;
   localparam logic [2:0] OP_XNOR  = 3'd7;

   typedef enum logic [1:0] {
      ST_STARTER = 2'd0,
      ST_INPUT   = 2'd1,
      ST_ENDER   = 2'd2
   } state_t;

   // Sliced down to the instance widths, so widths up to 64 bits are supported.
   localparam logic [63:0] ZERO_DATA    = 64'd0;
   localparam logic [63:0] ZERO_CONTROL = 64'd0;

   function automatic logic is_unary(input logic [2:0] opcode);
      return (opcode == OP_NOT_A) || (opcode == OP_NOT_B);
   endfunction

endpackage

// File: rtl/vector_logic_gate_alu.sv
// Combinational bitwise operator selected by a 3-bit opcode.
module logic_gate_alu
   import vector_logic_gate_pkg::*;
#(
   parameter int DATA_SIZE = 64
) (
   input  logic [2:0]           opcode_i,
   input  logic [DATA_SIZE-1:0] a_i,
   input  logic [DATA_SIZE-1:0] b_i,
   output logic [DATA_SIZE-1:0] result_o
);

   // Opcode decode into the selected bitwise function
   always_comb begin
      result_o = ZERO_DATA[DATA_SIZE-1:0];
      case (opcode_i)
         OP_NOT_A: result_o = ~a_i;
         OP_NOT_B: result_o = ~b_i;
         OP_AND:   result_o = a_i & b_i;
         OP_OR:    result_o = a_i | b_i;
         OP_XOR:   result_o = a_i ^ b_i;
         OP_NAND:  result_o = ~(a_i & b_i);
         OP_NOR:   result_o = ~(a_i | b_i);
         OP_XNOR:  result_o = ~(a_i ^ b_i);
         default:  result_o = ZERO_DATA[DATA_SIZE-1:0];
      endcase
   end

endmodule

// File: rtl/vector_logic_gate.sv
// Element-wise vector logic unit: collects operand pairs on request, applies the
// latched opcode and streams one registered result per element, then pulses READY.
module vector_logic_gate
   import vector_logic_gate_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [2:0]              OPCODE,
   input  logic [CONTROL_SIZE-1:0] SIZE_IN,
   input  logic                    DATA_A_IN_ENABLE,
   input  logic                    DATA_B_IN_ENABLE,
   input  logic [DATA_SIZE-1:0]    DATA_A_IN,
   input  logic [DATA_SIZE-1:0]    DATA_B_IN,
   output logic                    DATA_ENABLE,
   output logic                    DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]    DATA_OUT
);

   localparam logic [CONTROL_SIZE-1:0] ONE_CONTROL = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic [2:0]              opcode_q;
   logic [CONTROL_SIZE-1:0] size_q;
   logic [CONTROL_SIZE-1:0] index_q;
   logic [DATA_SIZE-1:0]    a_q;
   logic [DATA_SIZE-1:0]    b_q;
   logic                    flag_a_q;
   logic                    flag_b_q;
   logic                    ready_q;
   logic                    data_enable_q;
   logic                    data_out_enable_q;
   logic [DATA_SIZE-1:0]    data_out_q;

   logic                    flag_a_d;
   logic                    flag_b_d;
   logic                    operands_done_d;
   logic [DATA_SIZE-1:0]    alu_result;

   logic_gate_alu #(
      .DATA_SIZE (DATA_SIZE)
   ) u_alu (
      .opcode_i (opcode_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_result)
   );

   // Operand completion, counting a capture happening on this very edge
   always_comb begin
      flag_a_d        = flag_a_q | DATA_A_IN_ENABLE;
      flag_b_d        = flag_b_q | DATA_B_IN_ENABLE;
      operands_done_d = 1'b0;
      if (is_unary(opcode_q)) begin
         operands_done_d = (opcode_q == OP_NOT_A) ? flag_a_d : flag_b_d;
      end else begin
         operands_done_d = flag_a_d & flag_b_d;
      end
   end

   // Control FSM with registered handshake and data outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q           <= ST_STARTER;
         opcode_q          <= 3'd0;
         size_q            <= ZERO_CONTROL[CONTROL_SIZE-1:0];
         index_q           <= ZERO_CONTROL[CONTROL_SIZE-1:0];
         a_q               <= ZERO_DATA[DATA_SIZE-1:0];
         b_q               <= ZERO_DATA[DATA_SIZE-1:0];
         flag_a_q          <= 1'b0;
         flag_b_q          <= 1'b0;
         ready_q           <= 1'b0;
         data_enable_q     <= 1'b0;
         data_out_enable_q <= 1'b0;
         data_out_q        <= ZERO_DATA[DATA_SIZE-1:0];
      end else begin
         ready_q           <= 1'b0;
         data_enable_q     <= 1'b0;
         data_out_enable_q <= 1'b0;
         case (state_q)
            ST_STARTER: begin
               if (START) begin
                  opcode_q <= OPCODE;
                  size_q   <= SIZE_IN;
                  index_q  <= ZERO_CONTROL[CONTROL_SIZE-1:0];
                  flag_a_q <= 1'b0;
                  flag_b_q <= 1'b0;
                  if (SIZE_IN == ZERO_CONTROL[CONTROL_SIZE-1:0]) begin
                     ready_q <= 1'b1;
                  end else begin
                     data_enable_q <= 1'b1;
                     state_q       <= ST_INPUT;
                  end
               end
            end
            ST_INPUT: begin
               if (DATA_A_IN_ENABLE) begin
                  a_q      <= DATA_A_IN;
                  flag_a_q <= 1'b1;
               end
               if (DATA_B_IN_ENABLE) begin
                  b_q      <= DATA_B_IN;
                  flag_b_q <= 1'b1;
               end
               if (operands_done_d) begin
                  state_q <= ST_ENDER;
               end
            end
            ST_ENDER: begin
               data_out_q        <= alu_result;
               data_out_enable_q <= 1'b1;
               flag_a_q          <= 1'b0;
               flag_b_q          <= 1'b0;
               if (index_q == size_q - ONE_CONTROL) begin
                  ready_q <= 1'b1;
                  state_q <= ST_STARTER;
               end else begin
                  index_q       <= index_q + ONE_CONTROL;
                  data_enable_q <= 1'b1;
                  state_q       <= ST_INPUT;
               end
            end
            default: begin
               state_q <= ST_STARTER;
            end
         endcase
      end
   end

   assign READY           = ready_q;
   assign DATA_ENABLE     = data_enable_q;
   assign DATA_OUT_ENABLE = data_out_enable_q;
   assign DATA_OUT        = data_out_q;

endmodule

// File: tb/tb_vector_logic_gate.sv
// Scoreboard bench for vector_logic_gate with 8-bit data words.
module tb_vector_logic_gate;

   localparam int DW = 8;
   localparam int CW = 64;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic          READY;
   logic [2:0]    OPCODE;
   logic [CW-1:0] SIZE_IN;
   logic          DATA_A_IN_ENABLE;
   logic          DATA_B_IN_ENABLE;
   logic [DW-1:0] DATA_A_IN;
   logic [DW-1:0] DATA_B_IN;
   logic          DATA_ENABLE;
   logic          DATA_OUT_ENABLE;
   logic [DW-1:0] DATA_OUT;

   int checks = 0;
   int errors = 0;
   int out_count = 0;
   int ready_count = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb_q[$];

   vector_logic_gate #(
      .DATA_SIZE    (DW),
      .CONTROL_SIZE (CW)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .START            (START),
      .READY            (READY),
      .OPCODE           (OPCODE),
      .SIZE_IN          (SIZE_IN),
      .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
      .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
      .DATA_A_IN        (DATA_A_IN),
      .DATA_B_IN        (DATA_B_IN),
      .DATA_ENABLE      (DATA_ENABLE),
      .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
      .DATA_OUT         (DATA_OUT)
   );

   always #5 CLK = ~CLK;

   // Output monitor: pops the scoreboard on every result strobe
   always @(negedge CLK) begin
      exp_t e;
      if (READY === 1'b1) ready_count++;
      if (DATA_OUT_ENABLE === 1'b1) begin
         out_count++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: DATA_OUT=%h but no result expected", DATA_OUT);
         end else begin
            e = sb_q.pop_front();
            if (DATA_OUT !== e.data) begin
               errors++;
               $display("FAIL data_out: got %h expected %h", DATA_OUT, e.data);
            end
            checks++;
            if (READY !== e.last) begin
               errors++;
               $display("FAIL ready_with_result: got %b expected %b", READY, e.last);
            end
            checks++;
            if (DATA_ENABLE !== ~e.last) begin
               errors++;
               $display("FAIL data_enable_with_result: got %b expected %b", DATA_ENABLE, ~e.last);
            end
         end
      end
   end

   task automatic push_exp(input logic [DW-1:0] d, input logic last);
      exp_t e;
      e.data = d;
      e.last = last;
      sb_q.push_back(e);
   endtask

   task automatic start_vec(input logic [2:0] op, input logic [CW-1:0] size);
      START   = 1'b1;
      OPCODE  = op;
      SIZE_IN = size;
      @(negedge CLK);
      START   = 1'b0;
   endtask

   task automatic wait_den();
      int n;
      n = 0;
      while (DATA_ENABLE !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if (DATA_ENABLE !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL data_enable_timeout: got %b expected 1 within 20 cycles", DATA_ENABLE);
      end
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic aen, input logic ben);
      wait_den();
      DATA_A_IN        = a;
      DATA_B_IN        = b;
      DATA_A_IN_ENABLE = aen;
      DATA_B_IN_ENABLE = ben;
      @(negedge CLK);
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge CLK);
         #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", READY); end
      checks++;
      if (DATA_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_data_enable: got %b expected 0", DATA_ENABLE); end
      checks++;
      if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_out_enable: got %b expected 0", DATA_OUT_ENABLE); end
      checks++;
      if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", DATA_OUT); end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_and();
      int r0;
      int o0;
      r0 = ready_count;
      o0 = out_count;
      start_vec(3'd2, 64'd3);
      checks++;
      if (DATA_ENABLE !== 1'b1) begin errors++; $display("FAIL and_first_request: got %b expected 1", DATA_ENABLE); end
      push_exp(8'h30, 1'b0);
      send(8'hF0, 8'h3C, 1'b1, 1'b1);
      push_exp(8'h00, 1'b0);
      send(8'hFF, 8'h00, 1'b1, 1'b1);
      push_exp(8'h00, 1'b1);
      send(8'hAA, 8'h55, 1'b1, 1'b1);
      drain();
      checks++;
      if (out_count - o0 != 3) begin errors++; $display("FAIL and_result_count: got %0d expected 3", out_count - o0); end
      checks++;
      if (ready_count - r0 != 1) begin errors++; $display("FAIL and_ready_count: got %0d expected 1", ready_count - r0); end
   endtask

   task automatic test_not_a();
      int r0;
      r0 = ready_count;
      start_vec(3'd0, 64'd2);
      push_exp(8'hF0, 1'b0);
      send(8'h0F, 8'h00, 1'b1, 1'b0);
      push_exp(8'h7E, 1'b1);
      send(8'h81, 8'h00, 1'b1, 1'b0);
      drain();
      checks++;
      if (ready_count - r0 != 1) begin errors++; $display("FAIL not_a_ready_count: got %0d expected 1", ready_count - r0); end
   endtask

   task automatic test_xnor_latency();
      start_vec(3'd7, 64'd1);
      wait_den();
      push_exp(8'h33, 1'b1);
      DATA_A_IN        = 8'hC3;
      DATA_A_IN_ENABLE = 1'b1;
      @(negedge CLK);
      DATA_A_IN_ENABLE = 1'b0;
      checks++;
      if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL xnor_early_a1: got %b expected 0", DATA_OUT_ENABLE); end
      @(negedge CLK);
      checks++;
      if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL xnor_early_a2: got %b expected 0", DATA_OUT_ENABLE); end
      @(negedge CLK);
      DATA_B_IN        = 8'h0F;
      DATA_B_IN_ENABLE = 1'b1;
      @(negedge CLK);
      DATA_B_IN_ENABLE = 1'b0;
      // B's edge moves the FSM to ENDER; the following edge registers the result
      checks++;
      if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL xnor_early_b: got %b expected 0", DATA_OUT_ENABLE); end
      @(negedge CLK);
      checks++;
      if (DATA_OUT_ENABLE !== 1'b1) begin errors++; $display("FAIL xnor_latency: got %b expected 1", DATA_OUT_ENABLE); end
      drain();
   endtask

   task automatic test_size_zero();
      start_vec(3'd2, 64'd0);
      checks++;
      if (READY !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", READY); end
      checks++;
      if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL zero_out_enable: got %b expected 0", DATA_OUT_ENABLE); end
      checks++;
      if (DATA_OUT !== 8'h33) begin errors++; $display("FAIL zero_data_hold: got %h expected 33", DATA_OUT); end
      checks++;
      if (DATA_ENABLE !== 1'b0) begin errors++; $display("FAIL zero_data_enable: got %b expected 0", DATA_ENABLE); end
      @(negedge CLK);
      checks++;
      if (READY !== 1'b0) begin errors++; $display("FAIL zero_ready_pulse: got %b expected 0", READY); end
   endtask

   task automatic test_reset_mid();
      int r0;
      start_vec(3'd2, 64'd4);
      push_exp(8'h11, 1'b0);
      send(8'hF1, 8'h1F, 1'b1, 1'b1);
      drain();
      r0 = ready_count;
      wait_den();
      DATA_A_IN        = 8'h55;
      DATA_A_IN_ENABLE = 1'b1;
      @(negedge CLK);
      DATA_A_IN_ENABLE = 1'b0;
      #2 RST = 1'b1;
      #1;
      checks++;
      if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL midreset_data_out: got %h expected 00", DATA_OUT); end
      checks++;
      if (DATA_ENABLE !== 1'b0 || DATA_OUT_ENABLE !== 1'b0 || READY !== 1'b0) begin
         errors++;
         $display("FAIL midreset_strobes: got %b%b%b expected 000", DATA_ENABLE, DATA_OUT_ENABLE, READY);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (ready_count != r0) begin errors++; $display("FAIL midreset_no_ready: got %0d expected %0d", ready_count, r0); end
      start_vec(3'd3, 64'd1);
      push_exp(8'h81, 1'b1);
      send(8'h01, 8'h80, 1'b1, 1'b1);
      drain();
      checks++;
      if (ready_count - r0 != 1) begin errors++; $display("FAIL restart_ready: got %0d expected 1", ready_count - r0); end
   endtask

   task automatic test_ignore_mid_vector();
      int r0;
      int o0;
      r0 = ready_count;
      o0 = out_count;
      start_vec(3'd4, 64'd2);
      push_exp(8'hFF, 1'b0);
      wait_den();
      DATA_A_IN        = 8'h0F;
      DATA_B_IN        = 8'hF0;
      DATA_A_IN_ENABLE = 1'b1;
      DATA_B_IN_ENABLE = 1'b1;
      @(negedge CLK);
      START            = 1'b1;
      OPCODE           = 3'd2;
      SIZE_IN          = 64'd5;
      DATA_A_IN        = 8'hFF;
      DATA_B_IN        = 8'hFF;
      @(negedge CLK);
      START            = 1'b0;
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
      push_exp(8'h33, 1'b1);
      wait_den();
      DATA_A_IN        = 8'h3C;
      DATA_B_IN        = 8'h0F;
      DATA_A_IN_ENABLE = 1'b1;
      DATA_B_IN_ENABLE = 1'b1;
      START            = 1'b1;
      @(negedge CLK);
      START            = 1'b0;
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
      drain();
      repeat (10) @(negedge CLK);
      checks++;
      if (out_count - o0 != 2) begin errors++; $display("FAIL ignore_result_count: got %0d expected 2", out_count - o0); end
      checks++;
      if (ready_count - r0 != 1) begin errors++; $display("FAIL ignore_ready_count: got %0d expected 1", ready_count - r0); end
   endtask

   initial begin
      RST              = 1'b1;
      START            = 1'b0;
      OPCODE           = 3'd0;
      SIZE_IN          = 64'd0;
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
      DATA_A_IN        = 8'h00;
      DATA_B_IN        = 8'h00;
      test_reset();
      test_and();
      test_not_a();
      test_xnor_latency();
      test_size_zero();
      test_reset_mid();
      test_ignore_mid_vector();
      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule
